load_store_unit: RTL and testbench

Memory-stage block of the RV32I core. It sits between execute and the register file write port.
- Accepts one load/store request at a time from execute.
- Runs a valid/ready transaction on the data-memory bus.
- Aligns and sign- or zero-extends load data.
- Drives a single-cycle writeback (wb_en, wb_rd, wb_data) straight into the register file's reg_write/rd/write_data.

---
 rtl/load_store_unit_pkg.sv | 46 ++++
 rtl/load_store_unit_if.sv | 27 ++
 rtl/load_store_unit_load_align.sv | 40 ++++
 rtl/load_store_unit.sv | 204 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// Module   : load_store_unit_pkg
// Purpose  : Shared definitions for the RV32I load/store unit: funct3 width
//            codes, the FSM state encoding and the access legality check.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

  // RV32I funct3 width/sign codes for LOAD/STORE
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_WB    = 2'd2,
    ST_FAULT = 2'd3
  } lsu_state_t;

  // 1 when funct3 is legal for the op type and the address is naturally
  // aligned for the access width.
  function automatic logic access_ok(input logic       store,
                                     input logic [2:0] funct3,
                                     input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = !off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = !store;
      F3_HU:   ok = !store && !off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_if.sv
// ============================================================================
// Module   : load_store_unit_if
// Purpose  : Data-memory bus between the load/store unit (master) and the
//            data memory (slave). Single outstanding valid/ready transaction.
// Signals  : valid  - master request
//            ready  - slave completion
//            addr   - word-aligned address
//            wdata  - lane-shifted store data
//            wstrb  - byte enables (0000 for loads)
//            rdata  - read word, meaningful while ready=1
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface load_store_unit_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
// ============================================================================
// Module   : load_align
// Purpose  : Combinational load formatter. Selects the byte/halfword lane of
//            the read word by the low address bits and sign- or zero-extends
//            it according to funct3. Word loads pass through unchanged.
// Ports    : rdata    in  32  read word from the bus
//            byte_off in  2   address bits [1:0]
//            funct3   in  3   RV32I load width/sign code
//            result   out 32  formatted register value
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  // Move the addressed lane down to bit 0 so all widths extract from [15:0].
  logic [31:0] w_shifted;
  assign w_shifted = rdata >> {byte_off, 3'b000};

  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{w_shifted[7]}},  w_shifted[7:0]};
      F3_H:    result = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_BU:   result = {24'b0, w_shifted[7:0]};
      F3_HU:   result = {16'b0, w_shifted[15:0]};
      default: result = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV32I memory stage. Accepts one load/store from execute, runs a
//            valid/ready transaction on the data bus, formats load data and
//            produces a single-cycle register-file write. Misaligned/illegal
//            ops and bus timeouts retire as one-cycle fault pulses.
// Ports    : clk, resetn                  clock, async active-low reset
//            req_valid/req_ready          execute handshake
//            req_store/funct3/addr/wdata/rd  latched request fields
//            mem (master modport)         data-memory bus
//            wb_en/wb_rd/wb_data          register-file write port
//            done                         op retired (load, store or fault)
//            misaligned                   misaligned access / illegal funct3
//            access_fault                 bus timeout
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN    = 32,  // only 32 is supported
  parameter int TIMEOUT = 16   // 0 disables the bus timeout
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  input  logic [4:0]       req_rd,
  load_store_unit_if.master mem,
  output logic             wb_en,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             done,
  output logic             misaligned,
  output logic             access_fault
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  lsu_state_t state_q, state_d;

  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [3:0]       r_mem_wstrb;
  logic [1:0]       r_off;
  logic [2:0]       r_funct3;
  logic [4:0]       r_rd;
  logic             r_store;
  logic             r_fault_misaligned;
  logic             r_store_done;
  logic [CNT_W-1:0] r_timer;
  logic [31:0]      r_wb_data;
  logic [4:0]       r_wb_rd;

  logic             w_req_ok;
  logic             w_accept;
  logic             w_timeout;
  logic             w_mem_valid;
  logic [31:0]      w_lane_wdata;
  logic [3:0]       w_lane_wstrb;
  logic [31:0]      w_load_result;

  assign w_req_ok = access_ok(req_store, req_funct3, req_addr[1:0]);
  assign w_accept = (state_q == ST_IDLE) && req_valid;

  // Timer holds the number of completed wait cycles; the cycle in which it
  // sits at TIMEOUT-1 is the last one mem_ready may still complete in.
  assign w_timeout = (TIMEOUT != 0) && (r_timer == CNT_W'(TIMEOUT - 1));

  // Store lane placement: narrow data is replicated across the word so the
  // strobe alone selects the lane.
  always_comb begin
    w_lane_wdata = req_wdata;
    w_lane_wstrb = 4'b1111;
    case (req_funct3)
      F3_B: begin
        w_lane_wdata = {4{req_wdata[7:0]}};
        w_lane_wstrb = 4'b0001 << req_addr[1:0];
      end
      F3_H: begin
        w_lane_wdata = {2{req_wdata[15:0]}};
        w_lane_wstrb = 4'b0011 << req_addr[1:0];
      end
      default: ;
    endcase
    if (!req_store) begin
      w_lane_wstrb = 4'b0000;
    end
  end

  load_align u_load_align (
    .rdata    (mem.rdata),
    .byte_off (r_off),
    .funct3   (r_funct3),
    .result   (w_load_result)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    w_mem_valid  = 1'b0;
    wb_en        = 1'b0;
    done         = 1'b0;
    misaligned   = 1'b0;
    access_fault = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        done      = r_store_done;
        if (req_valid) begin
          state_d = w_req_ok ? ST_BUS : ST_FAULT;
        end
      end
      ST_BUS: begin
        w_mem_valid = 1'b1;
        if (mem.ready) begin
          state_d = r_store ? ST_IDLE : ST_WB;
        end else if (w_timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        wb_en   = (r_rd != 5'd0);
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        done         = 1'b1;
        misaligned   = r_fault_misaligned;
        access_fault = !r_fault_misaligned;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture, bus timer and writeback registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem_addr         <= '0;
      r_mem_wdata        <= '0;
      r_mem_wstrb        <= '0;
      r_off              <= '0;
      r_funct3           <= '0;
      r_rd               <= '0;
      r_store            <= 1'b0;
      r_fault_misaligned <= 1'b0;
      r_store_done       <= 1'b0;
      r_timer            <= '0;
      r_wb_data          <= '0;
      r_wb_rd            <= '0;
    end else begin
      r_store_done <= 1'b0;
      if (w_accept) begin
        r_mem_addr         <= {req_addr[31:2], 2'b00};
        r_mem_wdata        <= w_lane_wdata;
        r_mem_wstrb        <= w_lane_wstrb;
        r_off              <= req_addr[1:0];
        r_funct3           <= req_funct3;
        r_rd               <= req_rd;
        r_store            <= req_store;
        r_fault_misaligned <= !w_req_ok;
        r_timer            <= '0;
      end
      if (state_q == ST_BUS) begin
        if (mem.ready) begin
          if (r_store) begin
            r_store_done <= 1'b1;
          end else begin
            r_wb_data <= w_load_result;
            r_wb_rd   <= r_rd;
          end
        end else if (TIMEOUT != 0) begin
          r_timer <= r_timer + CNT_W'(1);
        end
      end
    end
  end

  assign mem.valid = w_mem_valid;
  assign mem.addr  = r_mem_addr;
  assign mem.wdata = r_mem_wdata;
  assign mem.wstrb = r_mem_wstrb;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit and load_align.
//            Directed cases followed by random load/store traffic, with
//            expected values from an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        done;
  logic        misaligned;
  logic        access_fault;

  logic [31:0] la_rdata = '0;
  logic [1:0]  la_off = '0;
  logic [2:0]  la_f3 = '0;
  logic [31:0] la_result;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_wb_data = '0;
  logic [4:0]  last_wb_rd = '0;

  load_store_unit_if mem_if ();

  load_store_unit #(.XLEN(32), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .mem          (mem_if),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .done         (done),
    .misaligned   (misaligned),
    .access_fault (access_fault)
  );

  load_align u_align (
    .rdata    (la_rdata),
    .byte_off (la_off),
    .funct3   (la_f3),
    .result   (la_result)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off,
                                             input logic [31:0] word);
    int sz;
    longint unsigned span, v;
    sz = size_of(f3);
    if (sz == 4 || sz == 0) return word;
    span = 64'd1 << (8 * sz);
    v = (longint'(word) >> (8 * off)) % span;
    if (!f3[2] && v >= span / 2) v = v + (64'h1_0000_0000 - span);
    return v[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete op; waits = wait states before mem_ready (>= TIMEOUT never completes)
  task automatic run_op(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd, input int waits,
                        input logic [31:0] rdata);
    int sz, off, m;
    bit ok;
    logic [31:0] exp_wdata, exp_res;
    logic [3:0] exp_strb;
    longint unsigned v, mult;
    sz  = size_of(f3);
    off = int'(addr % 4);
    ok  = (sz != 0) && !(store && f3[2]);
    if (ok) ok = ((off % sz) == 0);
    m = store ? (((1 << sz) - 1) << off) : 0;
    exp_strb = m[3:0];
    mult = (sz == 1) ? 64'h01010101 : (sz == 2) ? 64'h00010001 : 64'd1;
    v = (sz == 4 || sz == 0) ? longint'(wdata) : longint'(wdata) % (64'd1 << (8 * sz));
    v = v * mult;
    exp_wdata = v[31:0];
    exp_res = model_load(f3, off, rdata);

    @(negedge clk);
    check("pre_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_store = store; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0; req_wdata = $urandom(); req_addr = $urandom();

    if (!ok) begin
      check("mis_pulse", 32'(misaligned), 32'd1);
      check("mis_done", 32'(done), 32'd1);
      check("mis_afault", 32'(access_fault), 32'd0);
      check("mis_wb_en", 32'(wb_en), 32'd0);
      check("mis_no_bus", 32'(mem_if.valid), 32'd0);
      check("mis_wb_hold", wb_data, last_wb_data);
      @(negedge clk);
      check("mis_after_ready", 32'(req_ready), 32'd1);
      check("mis_after_pulse", 32'({misaligned, done}), 32'd0);
      return;
    end

    for (int c = 0; c < TIMEOUT; c++) begin
      check("bus_valid", 32'(mem_if.valid), 32'd1);
      check("bus_addr", mem_if.addr, {addr[31:2], 2'b00});
      check("bus_wstrb", 32'(mem_if.wstrb), 32'(exp_strb));
      if (store) check("bus_wdata", mem_if.wdata, exp_wdata);
      check("bus_busy", 32'({req_ready, done, wb_en}), 32'd0);
      mem_if.ready = (c == waits);
      mem_if.rdata = (c == waits) ? rdata : $urandom();
      @(negedge clk);
      mem_if.ready = 1'b0;
      mem_if.rdata = $urandom();
      if (c == waits) begin
        check("fin_no_bus", 32'(mem_if.valid), 32'd0);
        check("fin_done", 32'(done), 32'd1);
        check("fin_faults", 32'({misaligned, access_fault}), 32'd0);
        if (store) begin
          check("st_wb_en", 32'(wb_en), 32'd0);
          check("st_wb_hold", wb_data, last_wb_data);
          check("st_req_ready", 32'(req_ready), 32'd1);
        end else begin
          check("ld_wb_en", 32'(wb_en), 32'(rd != 5'd0));
          check("ld_wb_rd", 32'(wb_rd), 32'(rd));
          check("ld_wb_data", wb_data, exp_res);
          last_wb_data = exp_res;
          last_wb_rd = rd;
        end
        @(negedge clk);
        check("post_idle", 32'({req_ready, done, wb_en}), 32'b100);
        check("post_wb_hold", wb_data, last_wb_data);
        check("post_wb_rd_hold", 32'(wb_rd), 32'(last_wb_rd));
        return;
      end
    end
    check("to_afault", 32'(access_fault), 32'd1);
    check("to_done", 32'(done), 32'd1);
    check("to_mis", 32'(misaligned), 32'd0);
    check("to_wb_en", 32'(wb_en), 32'd0);
    check("to_no_bus", 32'(mem_if.valid), 32'd0);
    @(negedge clk);
    check("to_after", 32'({req_ready, done, access_fault}), 32'b100);
  endtask

  initial begin
    logic [2:0] legal_f3 [5];
    logic [2:0] f3;
    int r, waits;
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    mem_if.ready = 1'b0;
    mem_if.rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_valid", 32'(mem_if.valid), 32'd0);
    check("rst_pulses", 32'({wb_en, done, misaligned, access_fault}), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_mem_addr", mem_if.addr, 32'd0);
    check("rst_wstrb", 32'(mem_if.wstrb), 32'd0);
    resetn = 1'b1;

    // Directed
    run_op(1'b0, F3_W,  32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF);
    run_op(1'b0, F3_B,  32'h103, 32'h0, 5'd7, 0, 32'h80112233);
    run_op(1'b0, F3_BU, 32'h103, 32'h0, 5'd7, 2, 32'h80112233);
    run_op(1'b0, F3_HU, 32'h102, 32'h0, 5'd8, 1, 32'h80112233);
    run_op(1'b0, F3_H,  32'h102, 32'h0, 5'd9, 0, 32'h80112233);
    run_op(1'b1, F3_B,  32'h201, 32'h000000AB, 5'd3, 1, 32'h0);
    run_op(1'b1, F3_H,  32'h202, 32'h1234CDEF, 5'd3, 0, 32'h0);
    run_op(1'b1, F3_W,  32'h204, 32'hCAFEF00D, 5'd3, 3, 32'h0);
    run_op(1'b0, F3_W,  32'h102, 32'h0, 5'd4, 0, 32'h0);
    run_op(1'b1, F3_BU, 32'h200, 32'h0, 5'd4, 0, 32'h0);
    run_op(1'b0, 3'd3,  32'h200, 32'h0, 5'd4, 0, 32'h0);
    run_op(1'b0, F3_W,  32'h104, 32'h0, 5'd6, 100, 32'h11111111);
    run_op(1'b0, F3_W,  32'h108, 32'h0, 5'd6, TIMEOUT - 1, 32'h22222222);

    // Reset during BUS with 3 wait states
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = F3_W; req_addr = 32'h300; req_rd = 5'd9;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mid_bus_valid", 32'(mem_if.valid), 32'd1);
      @(negedge clk);
    end
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(mem_if.valid), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_wb", 32'({wb_en, done}), 32'd0);
    last_wb_data = '0;
    last_wb_rd = '0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_after_quiet", 32'({wb_en, done, mem_if.valid}), 32'd0);
    end
    check("mid_after_wb_data", wb_data, 32'd0);
    run_op(1'b0, F3_W, 32'h300, 32'h0, 5'd9, 0, 32'h5A5AA5A5);
    run_op(1'b0, F3_W, 32'h304, 32'h0, 5'd0, 1, 32'h12345678);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      waits = (r == 9) ? 20 : (r % 4);
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
      run_op(1'($urandom_range(0, 1)), f3, $urandom(), $urandom(),
             5'($urandom_range(0, 31)), waits, $urandom());
    end

    // load_align standalone
    for (int n = 0; n < 40; n++) begin
      la_rdata = $urandom();
      la_off = 2'($urandom_range(0, 3));
      la_f3 = legal_f3[$urandom_range(0, 4)];
      if (la_f3 == F3_W) la_off = 2'b00;
      if (la_f3 == F3_H || la_f3 == F3_HU) la_off[0] = 1'b0;
      #1;
      check("align_result", la_result, model_load(la_f3, int'(la_off), la_rdata));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
